// File: rtl/tm_input_sequencer.sv
// Stream-to-handshake front end for the Turing machine core: loads words as Next/Done
// pulses, then issues Next step pulses until Compute_done. Optional auto-run: TM_SEQ_AUTORUN_EN.
module tm_input_sequencer #(
  parameter int DW       = 4,
  parameter int PULSE_W  = 2,
  parameter int AUTO_DIV = 16,
  parameter int SCW      = 16
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           in_valid,
  input  logic [DW-1:0]  in_data,
  input  logic           in_last,
  output logic           in_ready,
  input  logic           step_req,
  input  logic           run,
  input  logic           compute_done,
  output logic [DW-1:0]  input_data,
  output logic           Next,
  output logic           Done,
  output logic           busy,
  output logic           halted,
  output logic [SCW-1:0] step_count,
  output logic [3:0]     state_dbg
);

  // Stream handshake: a word transfers on a rising clock edge where in_valid and
  // in_ready are both high; in_ready is only high in IDLE, so one word is in flight.

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LOAD_HI  = 4'd1,
    S_LOAD_LO  = 4'd2,
    S_DONE_HI  = 4'd3,
    S_DONE_LO  = 4'd4,
    S_RUN_IDLE = 4'd5,
    S_STEP_HI  = 4'd6,
    S_STEP_LO  = 4'd7,
    S_HALTED   = 4'd8
  } state_t;

  localparam int PHW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

  state_t         state;
  state_t         next_state;
  logic [PHW-1:0] phase;
  logic           phase_end;
  logic           timed;
  logic           accept;
  logic           step_start;
  logic           auto_fire;
  logic           last_q;

  assign phase_end = (phase == PHW'(PULSE_W - 1));
  assign state_dbg = state;

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    step_start = 1'b0;
    timed      = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_ready && in_valid) begin
          accept     = 1'b1;
          next_state = S_LOAD_HI;
        end
      end
      S_LOAD_HI: begin
        timed = 1'b1;
        if (phase_end) next_state = S_LOAD_LO;
      end
      S_LOAD_LO: begin
        timed = 1'b1;
        if (phase_end) next_state = last_q ? S_DONE_HI : S_IDLE;
      end
      S_DONE_HI: begin
        timed = 1'b1;
        if (phase_end) next_state = S_DONE_LO;
      end
      S_DONE_LO: begin
        timed = 1'b1;
        if (phase_end) next_state = S_RUN_IDLE;
      end
      S_RUN_IDLE: begin
        // Halt takes priority over a coincident step request or auto trigger.
        if (compute_done) begin
          next_state = S_HALTED;
        end else if (step_req || auto_fire) begin
          step_start = 1'b1;
          next_state = S_STEP_HI;
        end
      end
      S_STEP_HI: begin
        timed = 1'b1;
        if (phase_end) next_state = S_STEP_LO;
      end
      S_STEP_LO: begin
        timed = 1'b1;
        if (phase_end) next_state = S_RUN_IDLE;
      end
      S_HALTED: next_state = S_HALTED;
      default:  next_state = S_IDLE;
    endcase
  end

  // Outputs are registered from next_state so they line up with the state register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= S_IDLE;
      phase      <= '0;
      last_q     <= 1'b0;
      input_data <= '0;
      in_ready   <= 1'b0;
      Next       <= 1'b0;
      Done       <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      step_count <= '0;
    end else begin
      state    <= next_state;
      in_ready <= (next_state == S_IDLE);
      Next     <= (next_state == S_LOAD_HI) || (next_state == S_STEP_HI);
      Done     <= (next_state == S_DONE_HI);
      busy     <= (next_state != S_IDLE) && (next_state != S_HALTED);
      halted   <= (next_state == S_HALTED);

      if (next_state != state) begin
        phase <= '0;
      end else if (timed) begin
        phase <= phase + 1'b1;
      end

      if (accept) begin
        input_data <= in_data;
        last_q     <= in_last;
      end

      if (state == S_DONE_LO && phase_end) begin
        step_count <= '0;
      end else if (state == S_STEP_HI && phase_end && step_count != '1) begin
        step_count <= step_count + 1'b1;
      end
    end
  end

`ifdef TM_SEQ_AUTORUN_EN
  localparam int AW = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;

  logic [AW-1:0] auto_cnt;

  assign auto_fire = run && (state == S_RUN_IDLE) && (auto_cnt == AW'(AUTO_DIV - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      auto_cnt <= '0;
    end else if (step_start || !run) begin
      auto_cnt <= '0;
    end else if (state == S_RUN_IDLE) begin
      auto_cnt <= auto_cnt + 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign auto_fire  = 1'b0;
  assign unused_cfg = run & step_start & (AUTO_DIV > 0);
`endif

endmodule

// File: tb/tb_tm_input_sequencer.sv
// Bench for tm_input_sequencer: per-cycle vector table, directed corner sequences and
// randomized load/step traffic checked against a slot-arithmetic model.
module tb_tm_input_sequencer;

  localparam int PW = 2;
  localparam int AD = 4;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       step_req;
  logic       run;
  logic       compute_done;
  logic [3:0] input_data;
  logic       Next;
  logic       Done;
  logic       busy;
  logic       halted;
  logic [1:0] step_count;
  logic [3:0] state_dbg;

  tm_input_sequencer #(.DW(4), .PULSE_W(PW), .AUTO_DIV(AD), .SCW(2)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .step_req(step_req), .run(run),
    .compute_done(compute_done), .input_data(input_data), .Next(Next), .Done(Done),
    .busy(busy), .halted(halted), .step_count(step_count), .state_dbg(state_dbg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_chk;
  int n_fail;
  int cyc;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // Pulse monitor: widths, data stability, exclusivity, observed load words.
  int         rises;
  logic [3:0] obs_q[$];
  logic [3:0] exp_q[$];
  logic       prev_n, prev_d, rst_s;
  int         n_len, d_len;
  logic [3:0] n_data;

  initial begin
    prev_n = 1'b0; prev_d = 1'b0; n_len = 0; d_len = 0; rises = 0; n_data = '0;
    forever begin
      @(posedge clock);
      rst_s = reset;
      #1;
      if (!rst_s) begin
        n_len = 0;
        d_len = 0;
      end else begin
        chk("next_done_excl", int'(Next & Done), 0);
        if (Next && !prev_n) begin
          rises++;
          obs_q.push_back(input_data);
          n_data = input_data;
        end
        if (Next) begin
          n_len++;
          chk("pulse_data_stable", input_data, n_data);
        end else if (prev_n) begin
          chk("next_width", n_len, PW);
          n_len = 0;
        end
        if (Done) d_len++;
        else if (prev_d) begin
          chk("done_width", d_len, PW);
          d_len = 0;
        end
      end
      prev_n = Next;
      prev_d = Done;
    end
  end

  typedef struct {
    logic v; logic [3:0] d; logic l; logic sr;
    logic rdy; logic n; logic dn; logic [3:0] data; logic bsy; logic [1:0] cnt;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(logic v, logic [3:0] d, logic l, logic sr, logic rdy,
                              logic n, logic dn, logic [3:0] data, logic bsy, logic [1:0] cnt);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.sr = sr; t.rdy = rdy; t.n = n; t.dn = dn;
    t.data = data; t.bsy = bsy; t.cnt = cnt;
    vecs.push_back(t);
  endfunction

  task automatic do_reset();
    reset = 1'b0; in_valid = 1'b0; step_req = 1'b0; compute_done = 1'b0; run = 1'b0;
    in_data = '0; in_last = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic load_word(input logic [3:0] d, input logic l, output int acc);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) chk("load_timeout", n, 0);
    acc = cyc;
    tick();
    in_valid = 1'b0;
    exp_q.push_back(d);
  endtask

  task automatic wait_done(output int slot);
    int n;
    n = 0;
    while (!Done && n < 80) begin
      tick();
      n++;
    end
    if (n >= 80) chk("done_timeout", n, 0);
    slot = cyc;
  endtask

  initial begin
    int acc, dslot, free_slot, nacc, r0, nw, pn, rcnt;
    int rise_at[3];
    logic sr;
    n_chk = 0; n_fail = 0; cyc = 0;

    // Reset state and release.
    do_reset();
    reset = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_next", Next, 0);
    chk("rst_done", Done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_data", input_data, 0);
    chk("rst_count", step_count, 0);
    reset = 1'b1;
    tick();
    chk("release_in_ready", in_ready, 1);

    // Load 3,5,9 with in_valid held, Done, then one step with dropped extra requests.
    add(1,3,0,0, 0,1,0,3,1,0); add(1,5,0,0, 0,1,0,3,1,0); add(1,5,0,0, 0,0,0,3,1,0);
    add(1,5,0,0, 0,0,0,3,1,0); add(1,5,0,0, 1,0,0,3,0,0); add(1,5,0,0, 0,1,0,5,1,0);
    add(1,9,1,0, 0,1,0,5,1,0); add(1,9,1,0, 0,0,0,5,1,0); add(1,9,1,0, 0,0,0,5,1,0);
    add(1,9,1,0, 1,0,0,5,0,0); add(1,9,1,0, 0,1,0,9,1,0); add(0,0,0,0, 0,1,0,9,1,0);
    add(0,0,0,0, 0,0,0,9,1,0); add(0,0,0,0, 0,0,0,9,1,0); add(0,0,0,0, 0,0,1,9,1,0);
    add(0,0,0,0, 0,0,1,9,1,0); add(0,0,0,0, 0,0,0,9,1,0); add(0,0,0,0, 0,0,0,9,1,0);
    add(0,0,0,0, 0,0,0,9,1,0); add(1,7,0,1, 0,1,0,9,1,0); add(1,7,0,1, 0,1,0,9,1,0);
    add(1,7,0,0, 0,0,0,9,1,1); add(1,7,0,1, 0,0,0,9,1,1); add(1,7,0,0, 0,0,0,9,1,1);
    add(0,0,0,0, 0,0,0,9,1,1);
    for (int i = 0; i < vecs.size(); i++) begin
      in_valid = vecs[i].v; in_data = vecs[i].d; in_last = vecs[i].l; step_req = vecs[i].sr;
      tick();
      chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].rdy);
      chk($sformatf("vec%0d_next", i), Next, vecs[i].n);
      chk($sformatf("vec%0d_done", i), Done, vecs[i].dn);
      chk($sformatf("vec%0d_data", i), input_data, vecs[i].data);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].bsy);
      chk($sformatf("vec%0d_count", i), step_count, vecs[i].cnt);
    end
    in_valid = 1'b0; step_req = 1'b0;

    // Saturating step counter, then compute_done raised mid STEP_HI.
    do_reset();
    load_word(4'hA, 1'b1, acc);
    wait_done(dslot);
    repeat (2 * PW) tick();
    for (int k = 1; k <= 5; k++) begin
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      repeat (2 * PW) tick();
      chk($sformatf("sat_count_%0d", k), step_count, (k > 3) ? 3 : k);
    end
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    compute_done = 1'b1;
    tick();
    chk("halt_step_completes", Next, 1);
    repeat (2 * PW - 1) tick();
    chk("halt_not_yet", halted, 0);
    tick();
    chk("halted", halted, 1);
    chk("halted_busy", busy, 0);
    in_valid = 1'b1; in_data = 4'h2; in_last = 1'b1; step_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("halt_stays", halted, 1);
      chk("halt_no_next", Next, 0);
      chk("halt_no_ready", in_ready, 0);
    end
    in_valid = 1'b0; step_req = 1'b0; compute_done = 1'b0;

    // Reset during LOAD_HI aborts the pulse; a new load is accepted afterwards.
    do_reset();
    in_valid = 1'b1; in_data = 4'h6; in_last = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("abort_pre_next", Next, 1);
    reset = 1'b0;
    tick();
    chk("abort_next", Next, 0);
    chk("abort_state", state_dbg, 0);
    chk("abort_busy", busy, 0);
    reset = 1'b1;
    tick();
    chk("abort_ready", in_ready, 1);
    exp_q.delete();
    load_word(4'hC, 1'b1, acc);
    wait_done(dslot);
    chk("abort_reload_data", input_data, 12);
    chk("abort_done_latency", dslot, acc + 1 + 2 * PW);

`ifdef TM_SEQ_AUTORUN_EN
    // Auto-run cadence, then compute_done mid step.
    do_reset();
    run = 1'b1;
    load_word(4'h3, 1'b1, acc);
    wait_done(dslot);
    r0 = dslot + 2 * PW;
    rcnt = 0;
    pn = 0;
    for (int k = 0; k < 80 && rcnt < 3; k++) begin
      tick();
      if (Next && pn == 0) begin
        rise_at[rcnt] = cyc;
        rcnt++;
      end
      pn = Next;
    end
    chk("auto_rise_count", rcnt, 3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("auto_rise_%0d", k), rise_at[k], r0 + AD + k * (AD + 2 * PW));
    compute_done = 1'b1;
    tick();
    chk("auto_halt_step_completes", Next, 1);
    repeat (2 * PW - 1) tick();
    chk("auto_halt_not_yet", halted, 0);
    tick();
    chk("auto_halted", halted, 1);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("auto_halt_next_low", Next, 0);
    end
    compute_done = 1'b0; run = 1'b0;
`else
    // Without auto-run, run=1 alone never starts a step.
    do_reset();
    run = 1'b1;
    load_word(4'h3, 1'b1, acc);
    wait_done(dslot);
    r0 = rises;
    repeat (30) tick();
    chk("run_ignored", rises - r0, 0);
    run = 1'b0;
`endif

    // Randomized loads and step requests against slot-arithmetic model.
    for (int it = 0; it < 8; it++) begin
      do_reset();
      exp_q.delete();
      obs_q.delete();
      rises = 0;
      nw = $urandom_range(1, 4);
      for (int w = 0; w < nw; w++) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
        load_word(4'($urandom_range(0, 15)), (w == nw - 1), acc);
      end
      wait_done(dslot);
      chk("rnd_done_latency", dslot, acc + 1 + 2 * PW);
      chk("rnd_load_count", obs_q.size(), exp_q.size());
      for (int w = 0; w < nw && w < obs_q.size(); w++)
        chk($sformatf("rnd_word_%0d", w), obs_q[w], exp_q[w]);
      r0 = rises;
      free_slot = dslot + 2 * PW;
      nacc = 0;
      for (int k = 0; k < 60; k++) begin
        sr = ($urandom_range(0, 3) == 0);
        step_req = sr;
`ifndef TM_SEQ_AUTORUN_EN
        run = 1'($urandom_range(0, 1));
`endif
        if (sr && cyc >= free_slot) begin
          nacc++;
          free_slot = cyc + 2 * PW + 1;
        end
        tick();
      end
      step_req = 1'b0;
      run = 1'b0;
      repeat (2 * PW + 2) tick();
      chk("rnd_steps", rises - r0, nacc);
      chk("rnd_count", step_count, (nacc > 3) ? 3 : nacc);
      compute_done = 1'b1;
      repeat (2) tick();
      chk("rnd_halted", halted, 1);
      compute_done = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
